// File: rtl/spi_master_pkg.sv
// rtl/spi_master_pkg.sv - shared types and constants for the SPI register initiator
package spi_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    localparam logic [7:0] CMD_WR     = 8'h80;
    localparam logic [7:0] CMD_RD     = 8'h00;
    localparam int         FRAME_BITS = 32;
    localparam int         DATA_BITS  = 16;

    // Reads carry zeros in the data field so the slave sees a clean command.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic                 we,
        input logic [7:0]           addr,
        input logic [DATA_BITS-1:0] wdata
    );
        return we ? {CMD_WR, addr, wdata} : {CMD_RD, addr, {DATA_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/spi_reg_master_if.sv
// rtl/spi_reg_master_if.sv - request/response bus between a test sequencer and the SPI initiator
interface spi_reg_master_if;
    import spi_master_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [7:0]           req_addr;
    logic [DATA_BITS-1:0] req_wdata;
    logic                 rsp_valid;
    logic [DATA_BITS-1:0] rsp_rdata;
    logic                 busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy
    );

endinterface

// File: rtl/spi_sck_gen.sv
// rtl/spi_sck_gen.sv - SCK half-period divider with rise/fall strike pulses
module spi_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic CLK,
    input  logic rst_n,
    input  logic en,
    output logic rise,
    output logic fall,
    output logic sck
);

    localparam int            CW   = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          strike;

    // A strike ends the current half-period; its direction depends on the level being left.
    assign strike = en && (cnt == LAST);
    assign rise   = strike && !sck;
    assign fall   = strike && sck;

    // Half-period counter and registered SCK, parked low whenever disabled.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (strike) begin
            cnt <= '0;
            sck <= !sck;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_reg_master.sv
// rtl/spi_reg_master.sv - SPI mode-0 register initiator; SPI_MISO_SYNC_EN adds a 2-flop MISO synchroniser
module spi_reg_master
    import spi_master_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 4
) (
    input  logic            CLK,
    input  logic            rst_n,
    spi_reg_master_if.slave bus,
    output logic            spi_cs,
    output logic            spi_sck,
    output logic            spi_mosi,
    input  logic            spi_miso
);

    // The IDLE cycle that accepts the next request is the last cs-high cycle,
    // so GAP itself lasts one cycle less than the required cs-high time.
    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'((CS_GAP > 1) ? CS_GAP - 2 : 0);

    state_t                  state;
    state_t                  state_nx;
    logic [15:0]             tcnt;
    logic [5:0]              bit_cnt;
    logic [FRAME_BITS-1:0]   tx_sr;
    logic [DATA_BITS-1:0]    rx_sr;
    logic                    rd_op;
    logic                    accept;
    logic                    shift_en;
    logic                    sck_rise;
    logic                    sck_fall;
    logic                    sample;
    logic                    miso_s;
    logic                    hold_exit;
    logic                    rsp_valid_q;
    logic [DATA_BITS-1:0]    rsp_rdata_q;

    assign accept    = bus.req_valid && (state == IDLE);
    assign shift_en  = (state == SHIFT);
    assign hold_exit = (state == HOLD) && (tcnt == DIV_LAST);

    assign bus.req_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign spi_mosi      = tx_sr[FRAME_BITS-1];

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .CLK   (CLK),
        .rst_n (rst_n),
        .en    (shift_en),
        .rise  (sck_rise),
        .fall  (sck_fall),
        .sck   (spi_sck)
    );

`ifdef SPI_MISO_SYNC_EN
    logic [1:0] sync_ff;
    logic [1:0] rise_d;

    // Synchronise MISO and delay the sample strobe by the same two cycles.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= 2'b00;
            rise_d  <= 2'b00;
        end else begin
            sync_ff <= {sync_ff[0], spi_miso};
            rise_d  <= {rise_d[0], sck_rise};
        end
    end

    assign sample = rise_d[1];
    assign miso_s = sync_ff[1];

    // The delayed sample must land before the slave moves MISO on the next fall.
    always @(posedge CLK) begin
        assert (CLK_DIV >= 3) else $error("CLK_DIV must be at least 3 when MISO is synchronised");
    end
`else
    assign sample = sck_rise;
    assign miso_s = spi_miso;
`endif

    // State register.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state decode: fixed-length SETUP/HOLD/GAP around 64 SCK edges.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.req_valid) state_nx = SETUP;
            SETUP:   if (tcnt == DIV_LAST) state_nx = SHIFT;
            SHIFT:   if (sck_fall && (bit_cnt == 6'd63)) state_nx = HOLD;
            HOLD:    if (tcnt == DIV_LAST) state_nx = (CS_GAP > 1) ? GAP : IDLE;
            GAP:     if (tcnt == GAP_LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: dwell counter, edge counter, TX/RX shift registers, chip select and response.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            tcnt        <= '0;
            bit_cnt     <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            rd_op       <= 1'b0;
            spi_cs      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            if (state_nx != state)                     tcnt <= '0;
            else if (state inside {SETUP, HOLD, GAP})  tcnt <= tcnt + 16'd1;

            if (accept)                    bit_cnt <= '0;
            else if (sck_rise || sck_fall) bit_cnt <= bit_cnt + 6'd1;

            if (accept) begin
                tx_sr <= build_frame(bus.req_we, bus.req_addr, bus.req_wdata);
                rd_op <= !bus.req_we;
            end else if (sck_fall) begin
                tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b0};
            end

            if (sample) rx_sr <= {rx_sr[DATA_BITS-2:0], miso_s};

            spi_cs      <= !(state_nx inside {SETUP, SHIFT, HOLD});
            rsp_valid_q <= hold_exit;
            if (hold_exit && rd_op) rsp_rdata_q <= rx_sr;
        end
    end

endmodule

// File: tb/tb_spi_reg_master.sv
// tb/tb_spi_reg_master.sv - self-checking bench for spi_reg_master with a bit-level SPI slave model
module tb_spi_reg_master;

`ifdef SPI_MISO_SYNC_EN
    localparam int D = 3;
`else
    localparam int D = 4;
`endif
    localparam int G   = 4;
    localparam int LAT = 66 * D;

    logic CLK = 1'b0;
    logic rst_n = 1'b0;
    logic spi_cs, spi_sck, spi_mosi;
    logic spi_miso = 1'b0;

    spi_reg_master_if bus ();

    spi_reg_master #(.CLK_DIV(D), .CS_GAP(G)) dut (
        .CLK      (CLK),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .spi_cs   (spi_cs),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic rsp_cs = 1'b0;
    logic [15:0] model_rdata = 16'h0000;
    logic [31:0] exp_mosi_q[$];
    logic [15:0] exp_rdata_q[$];

    logic [31:0] slv_word = 32'h0;
    logic [31:0] mosi_cap = 32'h0;
    int rise_cnt = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Mode-0 slave: captures MOSI on rising SCK, moves MISO just after falling SCK.
    always begin
        @(negedge spi_cs);
        rise_cnt = 0;
        mosi_cap = 32'h0;
        #1 spi_miso = slv_word[31];
        while (!spi_cs) begin
            @(posedge spi_sck or posedge spi_cs);
            if (!spi_cs) begin
                mosi_cap = {mosi_cap[30:0], spi_mosi};
                rise_cnt++;
                @(negedge spi_sck or posedge spi_cs);
                if (!spi_cs && rise_cnt < 32) #1 spi_miso = slv_word[5'(31 - rise_cnt)];
            end
        end
    end

    task automatic start_req(input logic we, input logic [7:0] a, input logic [15:0] wd,
                             input logic [31:0] sw, input logic keep_valid);
        int n = 0;
        @(negedge CLK);
        while (!bus.req_ready && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_ready_timeout: req_ready=%b required 1", bus.req_ready);
        end
        slv_word      = sw;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        exp_mosi_q.push_back(we ? {8'h80, a, wd} : {8'h00, a, 16'h0000});
        if (!we) model_rdata = sw[15:0];
        exp_rdata_q.push_back(model_rdata);
        @(posedge CLK);
        #1;
        if (!keep_valid) bus.req_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        int rdy_hi = 0;
        logic [31:0] em;
        logic [15:0] er;
        @(negedge CLK);
        while (bus.rsp_valid !== 1'b1 && n < LAT + 50) begin
            if (bus.req_ready) rdy_hi++;
            @(negedge CLK);
            n++;
        end
        rsp_cs = spi_cs;
        em = exp_mosi_q.pop_front();
        er = exp_rdata_q.pop_front();
        checks++;
        if (bus.rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s rsp_timeout: rsp_valid=%b required 1", tag, bus.rsp_valid);
        end
        checks++;
        if (cyc - acc_cyc !== LAT) begin
            errors++;
            $display("FAIL %s latency: got %0d required %0d", tag, cyc - acc_cyc, LAT);
        end
        checks++;
        if (mosi_cap !== em) begin
            errors++;
            $display("FAIL %s mosi_frame: got %h required %h", tag, mosi_cap, em);
        end
        checks++;
        if (rise_cnt !== 32) begin
            errors++;
            $display("FAIL %s sck_rises: got %0d required 32", tag, rise_cnt);
        end
        checks++;
        if (bus.rsp_rdata !== er) begin
            errors++;
            $display("FAIL %s rsp_rdata: got %h required %h", tag, bus.rsp_rdata, er);
        end
        checks++;
        if (rdy_hi !== 0) begin
            errors++;
            $display("FAIL %s ready_in_frame: got %0d high cycles required 0", tag, rdy_hi);
        end
        @(negedge CLK);
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s rsp_pulse_width: rsp_valid=%b required 0", tag, bus.rsp_valid);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        logic [6:0] got;
        got = {spi_cs, spi_sck, spi_mosi, bus.req_ready, bus.busy, bus.rsp_valid, |bus.rsp_rdata};
        checks++;
        if (got !== 7'b1001000) begin
            errors++;
            $display("FAIL %s outputs {cs,sck,mosi,ready,busy,rsp_valid,|rdata}: got %b required 1001000",
                     tag, got);
        end
        checks++;
        if (bus.rsp_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL %s rsp_rdata: got %h required 0000", tag, bus.rsp_rdata);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge CLK);
        check_reset_outputs("post_reset");
    endtask

    task automatic test_write();
        start_req(1'b1, 8'h12, 16'hA55A, 32'hFFFF_FFFF, 1'b0);
        checks++;
        if ({bus.req_ready, bus.busy} !== 2'b01) begin
            errors++;
            $display("FAIL write_accept {ready,busy}: got %b required 01", {bus.req_ready, bus.busy});
        end
        wait_rsp("write");
    endtask

    task automatic test_read(input logic [7:0] a, input logic [31:0] sw, input string tag);
        start_req(1'b0, a, 16'hFFFF, sw, 1'b0);
        wait_rsp(tag);
    endtask

    task automatic test_back_to_back();
        int cs_hi;
        int a1;
        int a2 = -1;
        start_req(1'b1, 8'h21, 16'h1357, 32'h0, 1'b1);
        a1 = acc_cyc;
        bus.req_addr  = 8'h22;
        bus.req_wdata = 16'h2468;
        exp_mosi_q.push_back(32'h8022_2468);
        exp_rdata_q.push_back(model_rdata);
        wait_rsp("b2b_first");
        cs_hi = rsp_cs ? 2 : 1;
        for (int i = 0; i < 64; i++) begin
            if (!spi_cs) break;
            if (bus.req_ready && bus.req_valid) begin
                @(posedge CLK);
                #1;
                bus.req_valid = 1'b0;
                a2 = cyc;
            end
            @(negedge CLK);
            if (spi_cs) cs_hi++;
        end
        checks++;
        if (cs_hi !== G) begin
            errors++;
            $display("FAIL b2b_cs_gap: got %0d cycles required %0d", cs_hi, G);
        end
        checks++;
        if (a2 - a1 !== LAT + G) begin
            errors++;
            $display("FAIL b2b_period: got %0d required %0d", a2 - a1, LAT + G);
        end
        bus.req_valid = 1'b0;
        acc_cyc = a2;
        wait_rsp("b2b_second");
    endtask

    task automatic test_ignored();
        int n = 0;
        int cs_lo = 0;
        int extra_rsp = 0;
        start_req(1'b1, 8'h3C, 16'h0FF0, 32'h0, 1'b0);
        while (rise_cnt < 5 && n < LAT) begin
            @(negedge CLK);
            n++;
        end
        bus.req_we    = 1'b1;
        bus.req_addr  = 8'h55;
        bus.req_wdata = 16'hDEAD;
        bus.req_valid = 1'b1;
        repeat (3) @(negedge CLK);
        bus.req_valid = 1'b0;
        wait_rsp("ignored");
        for (int i = 0; i < LAT + 20; i++) begin
            @(negedge CLK);
            if (!spi_cs) cs_lo++;
            if (bus.rsp_valid) extra_rsp++;
        end
        checks++;
        if (cs_lo !== 0 || extra_rsp !== 0) begin
            errors++;
            $display("FAIL ignored_second_frame: cs_low=%0d rsp=%0d required 0 0", cs_lo, extra_rsp);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int rsp_seen = 0;
        start_req(1'b0, 8'h03, 16'h0000, 32'h0000_5A5A, 1'b0);
        while (rise_cnt < 10 && n < LAT) begin
            @(negedge CLK);
            n++;
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid");
        exp_mosi_q.delete();
        exp_rdata_q.delete();
        model_rdata = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (bus.rsp_valid) rsp_seen++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            @(negedge CLK);
            if (bus.rsp_valid) rsp_seen++;
        end
        checks++;
        if (rsp_seen !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_rsp: got %0d pulses required 0", rsp_seen);
        end
        test_read(8'h03, 32'h0000_BEEF, "read_after_reset");
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 8'h00;
        bus.req_wdata = 16'h0000;
        test_reset();
        test_write();
        test_read(8'h03, 32'h1234_BEEF, "read_beef");
        test_back_to_back();
        test_read(8'hC4, 32'hFFFF_8001, "read_8001");
        test_ignored();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
